fx2_ep2_reader: RTL and testbench

- Host-to-FPGA side of the FX2 synchronous slave-FIFO link. Drains 16-bit words from EP2 (FIFO_ADR = 2'b00) using SLOE/SLRD.
- Parses each word stream into frames of SYNC, then N_PAIRS (I,Q) pairs, and presents them as a registered I/Q sample stream with valid/ready.
- Shares the FX2 bus with the EP6 writer through a bus_req/bus_gnt handshake. An external mux drives the FX2 pins from whichever side holds the grant.

---
 rtl/fx2_pkg.sv | 23 ++
 rtl/fx2_ep2_reader_if.sv | 26 ++
 rtl/fx2_frame_parser.sv | 83 ++++++++
 rtl/fx2_ep2_reader.sv | 100 ++++++++++
 tb/tb_fx2_ep2_reader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx2_pkg.sv
// Shared constants and state encodings for the FX2 slave-FIFO link blocks.
package fx2_pkg;

   localparam logic [1:0]  EP2          = 2'b00;
   localparam logic [1:0]  EP6          = 2'b10;
   localparam logic [15:0] SYNC_DEFAULT = 16'h7F7F;

   typedef enum logic [2:0] {
      B_IDLE,
      B_REQ,
      B_OE,
      B_READ,
      B_GAP,
      B_REL
   } bus_state_t;

   typedef enum logic [1:0] {
      P_HUNT,
      P_I,
      P_Q
   } parse_state_t;

endpackage

// File: rtl/fx2_ep2_reader_if.sv
// FX2 EP2 pin bundle plus the I/Q output stream of the reader.
interface fx2_ep2_reader_if;
   logic        FLAGA;
   logic [15:0] FD_IN;
   logic        SLRD;
   logic        SLOE;
   logic [1:0]  FIFO_ADR;
   logic        bus_req;
   logic        bus_gnt;
   logic [15:0] i_data;
   logic [15:0] q_data;
   logic        iq_valid;
   logic        iq_ready;
   logic        sync_err;
   logic [15:0] frame_cnt;

   modport master (
      input  FLAGA, FD_IN, bus_gnt, iq_ready,
      output SLRD, SLOE, FIFO_ADR, bus_req, i_data, q_data, iq_valid, sync_err, frame_cnt
   );

   modport slave (
      output FLAGA, FD_IN, bus_gnt, iq_ready,
      input  SLRD, SLOE, FIFO_ADR, bus_req, i_data, q_data, iq_valid, sync_err, frame_cnt
   );
endinterface

// File: rtl/fx2_frame_parser.sv
// Frame parser: SYNC hunt, I/Q pairing, registered pair output and frame counter.
//   state  | meaning
//   P_HUNT | discard words until SYNC
//   P_I    | next word is an I sample
//   P_Q    | next word is a Q sample; completes a pair
module fx2_frame_parser
   import fx2_pkg::*;
#(
   parameter logic [15:0] SYNC    = SYNC_DEFAULT,
   parameter int          N_PAIRS = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] word,
   input  logic        word_vld,
   input  logic        iq_ready,
   output logic [15:0] i_data,
   output logic [15:0] q_data,
   output logic        iq_valid,
   output logic        sync_err,
   output logic [15:0] frame_cnt,
   output logic        want_q
);

   localparam logic [7:0] LAST_PAIR = 8'(N_PAIRS - 1);

   parse_state_t state, state_nxt;
   logic [7:0]   pair_cnt;
   logic [15:0]  i_hold;
   logic         load;
   logic         serr_nxt;

   // Role of the next word to be fetched, looking past a word still waiting here.
   assign want_q = word_vld ? (state == P_I) : (state == P_Q);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      serr_nxt  = 1'b0;
      if (word_vld) begin
         unique case (state)
            P_HUNT: begin
               if (word == SYNC) state_nxt = P_I;
               else              serr_nxt  = 1'b1;
            end
            P_I: state_nxt = P_Q;
            P_Q: begin
               load      = 1'b1;
               state_nxt = (pair_cnt == LAST_PAIR) ? P_HUNT : P_I;
            end
            default: state_nxt = P_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= P_HUNT;
         pair_cnt  <= '0;
         i_hold    <= '0;
         i_data    <= '0;
         q_data    <= '0;
         iq_valid  <= 1'b0;
         sync_err  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state    <= state_nxt;
         sync_err <= serr_nxt;
         if (word_vld && state == P_HUNT) pair_cnt <= '0;
         if (word_vld && state == P_I)    i_hold   <= word;
         if (load) begin
            i_data   <= i_hold;
            q_data   <= word;
            iq_valid <= 1'b1;
            pair_cnt <= pair_cnt + 8'd1;
            if (state_nxt == P_HUNT) frame_cnt <= frame_cnt + 16'd1;
         end else if (iq_ready) begin
            iq_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fx2_ep2_reader.sv
// Host-to-FPGA EP2 reader: arbitrates for the FX2 bus, strobes SLRD and feeds the frame parser.
//   state  | meaning
//   B_IDLE | waiting for data and an output slot
//   B_REQ  | bus_req high, waiting for bus_gnt
//   B_OE   | SLOE low, FX2 data setup
//   B_READ | SLRD low, word captured at end of cycle
//   B_GAP  | SLRD high, absorbs flag latency, decides next read
//   B_REL  | drop SLOE and bus_req, clear burst count
module fx2_ep2_reader
   import fx2_pkg::*;
#(
   parameter logic [15:0] SYNC    = SYNC_DEFAULT,
   parameter int          N_PAIRS = 8,
   parameter int          BURST   = 16
) (
   input  logic                 IFCLK,
   input  logic                 reset_n,
   fx2_ep2_reader_if.master     bus
);

   localparam logic [7:0] BURST_MAX = 8'(BURST);

   bus_state_t  state, state_nxt;
   logic [7:0]  burst_cnt;
   logic [15:0] word;
   logic        word_vld;
   logic        slrd, sloe, req;
   logic        can_take, want_q, go;
   logic [15:0] i_data, q_data, frame_cnt;
   logic        iq_valid, sync_err;

   // A Q word is only fetched when its pair is guaranteed an output slot.
   assign can_take = !want_q || !iq_valid || bus.iq_ready;
   assign go       = bus.FLAGA && can_take && bus.bus_gnt;

   always_comb begin
      state_nxt = state;
      unique case (state)
         B_IDLE:  if (bus.FLAGA && can_take) state_nxt = B_REQ;
         B_REQ:   if (bus.bus_gnt) state_nxt = B_OE;
         B_OE:    state_nxt = go ? B_READ : B_REL;
         B_READ:  state_nxt = B_GAP;
         B_GAP:   state_nxt = (go && burst_cnt < BURST_MAX) ? B_READ : B_REL;
         B_REL:   state_nxt = B_IDLE;
         default: state_nxt = B_IDLE;
      endcase
   end

   always_ff @(posedge IFCLK) begin
      if (!reset_n) begin
         state     <= B_IDLE;
         slrd      <= 1'b1;
         sloe      <= 1'b1;
         req       <= 1'b0;
         burst_cnt <= '0;
         word      <= '0;
         word_vld  <= 1'b0;
      end else begin
         state    <= state_nxt;
         slrd     <= (state_nxt != B_READ);
         sloe     <= !(state_nxt inside {B_OE, B_READ, B_GAP});
         req      <= (state_nxt inside {B_REQ, B_OE, B_READ, B_GAP});
         word_vld <= (state == B_READ);
         if (state == B_READ) begin
            word      <= bus.FD_IN;
            burst_cnt <= burst_cnt + 8'd1;
         end else if (state == B_REL) begin
            burst_cnt <= '0;
         end
      end
   end

   fx2_frame_parser #(
      .SYNC    (SYNC),
      .N_PAIRS (N_PAIRS)
   ) u_parser (
      .clk       (IFCLK),
      .reset_n   (reset_n),
      .word      (word),
      .word_vld  (word_vld),
      .iq_ready  (bus.iq_ready),
      .i_data    (i_data),
      .q_data    (q_data),
      .iq_valid  (iq_valid),
      .sync_err  (sync_err),
      .frame_cnt (frame_cnt),
      .want_q    (want_q)
   );

   assign bus.SLRD      = slrd;
   assign bus.SLOE      = sloe;
   assign bus.bus_req   = req;
   assign bus.FIFO_ADR  = EP2;
   assign bus.i_data    = i_data;
   assign bus.q_data    = q_data;
   assign bus.iq_valid  = iq_valid;
   assign bus.sync_err  = sync_err;
   assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_fx2_ep2_reader.sv
// Bench for fx2_ep2_reader: FX2 FIFO and arbiter models, stream-level frame model, directed and random phases.
module tb_fx2_ep2_reader;

   localparam logic [15:0] SYNC    = 16'h7F7F;
   localparam int          N_PAIRS = 2;
   localparam int          BURST   = 4;

   logic IFCLK = 1'b0;
   logic reset_n;
   always #5 IFCLK = ~IFCLK;

   fx2_ep2_reader_if bus ();

   fx2_ep2_reader #(.SYNC(SYNC), .N_PAIRS(N_PAIRS), .BURST(BURST)) dut (
      .IFCLK   (IFCLK),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0, errors = 0;
   int total_reads = 0, sloe_low = 0, serr_obs = 0, exp_serr = 0;
   int in_grant = 0, pairs_done = 0, q_due = 0, m_pos = -1;
   int gnt_mode = 0, rdy_mode = 0;
   logic [15:0] m_i, m_frames = '0;
   logic [31:0] lat_pair, prev_pair;
   logic prev_slrd, prev_req, prev_hold = 1'b0;
   logic [15:0] fifo[$];
   logic [31:0] exp_q[$];
   int grant_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame model on the stream of words actually taken from the FIFO.
   task automatic feed(input logic [15:0] w);
      if (m_pos < 0) begin
         if (w == SYNC) m_pos = 0;
         else           exp_serr++;
      end else begin
         if (m_pos % 2 == 0) m_i = w;
         else begin
            exp_q.push_back({m_i, w});
            lat_pair = {m_i, w};
            q_due    = 2;
         end
         m_pos++;
         if (m_pos == 2 * N_PAIRS) begin
            m_pos = -1;
            m_frames++;
         end
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pos = -1; m_frames = '0; q_due = 0;
      exp_serr = 0; serr_obs = 0; prev_hold = 1'b0; in_grant = 0;
   endtask

   task automatic drive_inputs();
      bus.FLAGA = (fifo.size() != 0);
      bus.FD_IN = (fifo.size() != 0) ? fifo[0] : 16'hDEAD;
      case (gnt_mode)
         0: bus.bus_gnt = 1'b1;
         1: bus.bus_gnt = 1'b0;
         default: if (!(bus.bus_req === 1'b1 && bus.bus_gnt === 1'b1))
                     bus.bus_gnt = ($urandom_range(0, 2) == 0);
      endcase
      case (rdy_mode)
         0: bus.iq_ready = 1'b1;
         1: bus.iq_ready = 1'b0;
         default: bus.iq_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic push(input logic [15:0] w);
      fifo.push_back(w);
      bus.FLAGA = 1'b1;
      bus.FD_IN = fifo[0];
   endtask

   task automatic tick();
      logic rd, hs, rst_edge;
      logic [15:0] w;
      logic [31:0] pair_obs;
      @(negedge IFCLK);
      rd = (bus.SLRD === 1'b0);
      pair_obs = {bus.i_data, bus.q_data};
      if (rd) begin
         total_reads++;
         chk("slrd_nonempty", 32'(fifo.size() != 0), 32'd1);
         chk("slrd_gnt", 32'(bus.bus_gnt), 32'd1);
         chk("slrd_sloe", 32'(bus.SLOE), 32'd0);
         chk("slrd_spacing", 32'(prev_slrd), 32'd1);
      end
      if (bus.SLOE === 1'b0) begin
         sloe_low++;
         chk("sloe_req", 32'(bus.bus_req), 32'd1);
      end
      if (bus.sync_err === 1'b1) serr_obs++;
      if (bus.bus_req === 1'b1) begin
         if (rd) begin
            in_grant++;
            chk("burst_limit", 32'(in_grant <= BURST), 32'd1);
         end
      end else if (prev_req === 1'b1) begin
         grant_log.push_back(in_grant);
         in_grant = 0;
      end
      if (prev_hold) begin
         chk("hold_valid", 32'(bus.iq_valid), 32'd1);
         chk("hold_data", pair_obs, prev_pair);
      end
      if (q_due != 0) begin
         q_due--;
         if (q_due == 0) begin
            chk("lat_valid", 32'(bus.iq_valid), 32'd1);
            chk("lat_pair", pair_obs, lat_pair);
         end
      end
      hs        = (bus.iq_valid === 1'b1) && (bus.iq_ready === 1'b1) && (reset_n === 1'b1);
      prev_hold = (bus.iq_valid === 1'b1) && (bus.iq_ready === 1'b0) && (reset_n === 1'b1);
      prev_pair = pair_obs;
      prev_slrd = bus.SLRD;
      prev_req  = bus.bus_req;
      rst_edge  = (reset_n !== 1'b1);
      @(posedge IFCLK);
      #1;
      if (rd && fifo.size() != 0) begin
         w = fifo.pop_front();
         if (!rst_edge) feed(w);
      end
      if (hs) begin
         pairs_done++;
         chk("pair_avail", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("pair_data", pair_obs, exp_q.pop_front());
      end
      drive_inputs();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   initial begin
      int r0, s0, p0, sl0;
      bit done;
      reset_n      = 1'b0;
      bus.FLAGA    = 1'b0;
      bus.FD_IN    = 16'hDEAD;
      bus.bus_gnt  = 1'b1;
      bus.iq_ready = 1'b1;
      run(3);
      chk("rst_slrd", 32'(bus.SLRD), 32'd1);
      chk("rst_sloe", 32'(bus.SLOE), 32'd1);
      chk("rst_req", 32'(bus.bus_req), 32'd0);
      chk("rst_valid", 32'(bus.iq_valid), 32'd0);
      chk("rst_serr", 32'(bus.sync_err), 32'd0);
      chk("rst_iq", {bus.i_data, bus.q_data}, 32'd0);
      chk("rst_frames", 32'(bus.frame_cnt), 32'd0);
      chk("fifo_adr", 32'(bus.FIFO_ADR), 32'd0);
      model_reset();
      reset_n = 1'b1;
      run(2);

      // basic frame with free-running output
      r0 = total_reads; p0 = pairs_done;
      push(SYNC); push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
      run(30);
      chk("p1_reads", 32'(total_reads - r0), 32'd5);
      chk("p1_pairs", 32'(pairs_done - p0), 32'd2);
      chk("p1_frames", 32'(bus.frame_cnt), 32'd1);
      chk("p1_released", {31'd0, bus.bus_req}, 32'd0);

      // leading garbage word
      s0 = serr_obs;
      push(16'h1234); push(SYNC); push(16'h0A0A); push(16'h0B0B); push(16'h0C0C); push(16'h0D0D);
      run(30);
      chk("p2_serr", 32'(serr_obs - s0), 32'd1);
      chk("p2_frames", 32'(bus.frame_cnt), 32'd2);

      // backpressure stalls the Q read
      rdy_mode = 1; bus.iq_ready = 1'b0;
      r0 = total_reads;
      push(SYNC); push(16'h0011); push(16'h0012); push(16'h0021); push(16'h0022);
      run(40);
      chk("p3_stall_reads", 32'(total_reads - r0), 32'd4);
      chk("p3_held_valid", 32'(bus.iq_valid), 32'd1);
      chk("p3_held_pair", {bus.i_data, bus.q_data}, {16'h0011, 16'h0012});
      rdy_mode = 0;
      run(30);
      chk("p3_reads", 32'(total_reads - r0), 32'd5);
      chk("p3_frames", 32'(bus.frame_cnt), 32'd3);

      // burst limit with a 10-word FIFO
      grant_log.delete();
      push(SYNC); push(16'h0031); push(16'h0032); push(16'h0033); push(16'h0034);
      push(SYNC); push(16'h0035); push(16'h0036); push(16'h0037); push(16'h0038);
      run(60);
      chk("p4_grants", 32'(grant_log.size()), 32'd3);
      if (grant_log.size() == 3) begin
         chk("p4_burst0", 32'(grant_log[0]), 32'd4);
         chk("p4_burst1", 32'(grant_log[1]), 32'd4);
         chk("p4_burst2", 32'(grant_log[2]), 32'd2);
      end
      chk("p4_frames", 32'(bus.frame_cnt), 32'd5);

      // no grant: request only
      gnt_mode = 1; bus.bus_gnt = 1'b0;
      r0 = total_reads; sl0 = sloe_low;
      push(SYNC); push(16'h0041); push(16'h0042); push(16'h0043); push(16'h0044);
      run(20);
      chk("p5_no_sloe", 32'(sloe_low - sl0), 32'd0);
      chk("p5_no_reads", 32'(total_reads - r0), 32'd0);
      chk("p5_req", 32'(bus.bus_req), 32'd1);
      gnt_mode = 0;
      run(30);
      chk("p5_frames", 32'(bus.frame_cnt), 32'd6);

      // random traffic, grant and backpressure
      gnt_mode = 2; rdy_mode = 2;
      for (int i = 0; i < 600; i++) begin
         if (fifo.size() < 12 && $urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 3) == 0) push(16'($urandom));
            else begin
               push(SYNC);
               for (int k = 0; k < 2 * N_PAIRS; k++) push(16'($urandom));
            end
         end
         tick();
      end
      gnt_mode = 0; rdy_mode = 0;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         done = (fifo.size() == 0) && (bus.bus_req === 1'b0) && (bus.iq_valid === 1'b0);
      end
      chk("drain_timeout", 32'(done), 32'd1);
      run(10);
      chk("rnd_frames", 32'(bus.frame_cnt), 32'(m_frames));
      chk("rnd_serr", 32'(serr_obs), 32'(exp_serr));
      chk("rnd_leftover", 32'(exp_q.size()), 32'd0);

      // reset in the middle of a READ
      r0 = total_reads;
      push(SYNC); push(16'h0051); push(16'h0052); push(16'h0053); push(16'h0054);
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         done = (bus.SLRD === 1'b0) && (total_reads - r0 >= 2);
      end
      chk("read_found", 32'(done), 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mid_rst_slrd", 32'(bus.SLRD), 32'd1);
      chk("mid_rst_sloe", 32'(bus.SLOE), 32'd1);
      chk("mid_rst_req", 32'(bus.bus_req), 32'd0);
      chk("mid_rst_valid", 32'(bus.iq_valid), 32'd0);
      chk("mid_rst_frames", 32'(bus.frame_cnt), 32'd0);
      model_reset();
      run(40);
      chk("post_rst_serr", 32'(serr_obs), 32'(exp_serr));
      chk("post_rst_frames", 32'(bus.frame_cnt), 32'(m_frames));
      chk("post_rst_fifo", 32'(fifo.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
